bcd_alarm_clock: RTL

Parametrised BCD real-time clock with a bank of independently programmable alarms, a 12/24-hour display mode and a snooze/dismiss ringing state machine. It advances a 24-hour hh:mm:ss counter from a prescaled tick and drives six BCD digits plus an AM flag for the display path. It compares the time against each enabled alarm and raises a single `alarm` output while any alarm is ringing.

---
 rtl/clock_pkg.sv | 47 ++++
 rtl/bcd_mod_counter.sv | 30 +++
 rtl/bcd_alarm_clock.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, limits and BCD helpers for bcd_alarm_clock
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  typedef struct packed {
    bcd2_t hh;
    bcd2_t mm;
    bcd2_t ss;
  } clock_time_t;

  typedef struct packed {
    logic  en;
    bcd2_t hh;
    bcd2_t mm;
  } alarm_slot_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} alarm_state_t;

  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_23 = 8'h23;

  // Both digits must be decimal; a valid BCD pair then orders like its value.
  function automatic logic bcd_valid(input bcd2_t v, input bcd2_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  // 24-hour BCD hour to 12-hour display hour.
  function automatic bcd2_t hour_to_12(input bcd2_t hh);
    if (hh == 8'h00) return 8'h12;
    if (hh <= 8'h12) return hh;
    if (hh[7:4] == 4'd1) return {4'd0, hh[3:0] - 4'd2};
    if (hh[3:0] < 4'd2) return {4'd0, hh[3:0] + 4'd8};
    return {4'd1, hh[3:0] - 4'd2};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX, with load and carry-out
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = BCD_59
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  bcd2_t load_value,
  input  logic  inc,
  output bcd2_t value,
  output bcd2_t value_next,
  output logic  carry
);

  assign carry = inc && !load && (value == MAX);

  always_comb begin
    value_next = value;
    if (load) value_next = load_value;
    else if (inc) value_next = (value == MAX) ? '0 : bcd_inc(value);
  end

  always_ff @(posedge clock) begin
    if (!reset) value <= '0;
    else value <= value_next;
  end

endmodule

// File: rtl/bcd_alarm_clock.sv
// rtl/bcd_alarm_clock.sv - BCD real-time clock with alarm bank and ringing FSM
// Optional snooze support: define ALARM_SNOOZE_EN.
module bcd_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int N_ALARMS      = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int IDX_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode_24,
  input  logic                set_time,
  input  logic [23:0]         set_value,
  input  logic                alarm_wr,
  input  logic [IDX_W-1:0]    alarm_idx,
  input  logic [16:0]         alarm_value,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [3:0]          q1,
  output logic [3:0]          q2,
  output logic [3:0]          q3,
  output logic [3:0]          q4,
  output logic [3:0]          q5,
  output logic [3:0]          q6,
  output logic                am,
  output logic                alarm,
  output logic [N_ALARMS-1:0] alarm_hit,
  output logic                sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  clock_time_t         set_t, now, nxt;
  alarm_slot_t         wr_slot;
  alarm_slot_t         slots [N_ALARMS];
  alarm_state_t        state;
  logic [PW-1:0]       presc;
  logic [N_ALARMS-1:0] wr_sel, match_vec;
  logic                load_ok, tick, sec_carry, min_carry, unused_hr_carry;
  bcd2_t               hr_disp;

  assign set_t   = set_value;
  assign wr_slot = alarm_value;
  assign load_ok = set_time && bcd_valid(set_t.hh, BCD_23) &&
                   bcd_valid(set_t.mm, BCD_59) && bcd_valid(set_t.ss, BCD_59);
  assign tick     = enable && !load_ok && (presc == PW'(TICKS_PER_SEC - 1));
  assign sec_tick = tick && reset;

  always_ff @(posedge clock) begin
    if (!reset || load_ok) presc <= '0;
    else if (enable) presc <= (presc == PW'(TICKS_PER_SEC - 1)) ? '0 : presc + PW'(1);
  end

  bcd_mod_counter #(.MAX(BCD_59)) u_sec (
    .clock(clock), .reset(reset), .load(load_ok), .load_value(set_t.ss), .inc(tick),
    .value(now.ss), .value_next(nxt.ss), .carry(sec_carry)
  );
  bcd_mod_counter #(.MAX(BCD_59)) u_min (
    .clock(clock), .reset(reset), .load(load_ok), .load_value(set_t.mm), .inc(sec_carry),
    .value(now.mm), .value_next(nxt.mm), .carry(min_carry)
  );
  bcd_mod_counter #(.MAX(BCD_23)) u_hr (
    .clock(clock), .reset(reset), .load(load_ok), .load_value(set_t.hh), .inc(min_carry),
    .value(now.hh), .value_next(nxt.hh), .carry(unused_hr_carry)
  );

  // Out-of-range indices decode to no slot at all.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_ALARMS; i++)
      wr_sel[i] = alarm_wr && (alarm_idx == IDX_W'(i)) &&
                  bcd_valid(wr_slot.hh, BCD_23) && bcd_valid(wr_slot.mm, BCD_59);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_ALARMS; i++) begin
      if (!reset) slots[i] <= '0;
      else if (wr_sel[i]) slots[i] <= wr_slot;
    end
  end

  // sec_carry is a tick into ss=00; compare against the time being written this edge.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < N_ALARMS; i++)
      match_vec[i] = sec_carry && slots[i].en && (slots[i].hh == nxt.hh) && (slots[i].mm == nxt.mm);
  end

`ifdef ALARM_SNOOZE_EN
  logic [5:0] snooze_cnt;
`else
  logic unused_snooze;
  assign unused_snooze = snooze & (SNOOZE_MIN > 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      alarm_hit <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (|match_vec) begin
          state     <= ST_RING;
          alarm_hit <= match_vec;
        end
        ST_RING: if (dismiss) begin
          state     <= ST_IDLE;
          alarm_hit <= '0;
        end else begin
          alarm_hit <= alarm_hit | match_vec;
`ifdef ALARM_SNOOZE_EN
          if (snooze) begin
            state      <= ST_SNOOZE;
            snooze_cnt <= 6'(SNOOZE_MIN);
          end
`endif
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: if (dismiss) begin
          state     <= ST_IDLE;
          alarm_hit <= '0;
        end else begin
          alarm_hit <= alarm_hit | match_vec;
          if (|match_vec) state <= ST_RING;
          else if (sec_carry) begin
            if (snooze_cnt == 6'd1) state <= ST_RING;
            snooze_cnt <= snooze_cnt - 6'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alarm   = (state == ST_RING);
  assign hr_disp = mode_24 ? now.hh : hour_to_12(now.hh);
  assign am      = (now.hh < 8'h12);
  assign q1 = now.ss[3:0];
  assign q2 = now.ss[7:4];
  assign q3 = now.mm[3:0];
  assign q4 = now.mm[7:4];
  assign q5 = hr_disp[3:0];
  assign q6 = hr_disp[7:4];

endmodule
